// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
    StChk,
    StDone,
    StError
  } state_e;

  localparam int unsigned HDR_WIDTH      = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_STRIDE    = 4;

  function automatic logic count_too_big(input logic [HDR_WIDTH-1:0] cnt,
                                         input int unsigned depth);
    return 32'(cnt) > depth;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: first byte of a word ends up in bits [31:24].
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (shift_en_i) begin
      word_d = {word_q[23:0], byte_i};
      idx_d  = idx_q + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a word-count header plus big-endian words into imem, holding the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_e                 state_q, state_d;
  logic [7:0]             hdr_hi_q, hdr_hi_d;
  logic [HDR_WIDTH-1:0]   remaining_q, remaining_d;
  logic [31:0]            addr_q, addr_d;
  logic [HDR_WIDTH-1:0]   hdr_cnt;
  logic                   accept;
  logic                   shift_en;
  logic                   last_byte;
  logic [31:0]            word;

  assign accept   = in_valid && in_ready;
  assign hdr_cnt  = {hdr_hi_q, in_byte};
  assign shift_en = accept && (state_q == StData);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d = xor_q;
    if (shift_en) begin
      xor_d = xor_q ^ in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  word_assembler u_word_assembler (
    .clk_i       (clk),
    .reset_i     (reset),
    .shift_en_i  (shift_en),
    .byte_i      (in_byte),
    .word_o      (word),
    .last_byte_o (last_byte)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHdrHi;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHdrHi: if (accept) state_d = StHdrLo;
      StHdrLo: begin
        if (accept) begin
          if (hdr_cnt == '0) begin
            state_d = StDone;
          end else if (count_too_big(hdr_cnt, DEPTH)) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: if (accept && last_byte) state_d = StWrite;
      StWrite: begin
        if (remaining_q == HDR_WIDTH'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
      StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = (in_byte == xor_q) ? StDone : StError;
`else
        state_d = StError;
`endif
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  // Datapath: header latch, remaining word count and write address
  always_comb begin
    hdr_hi_d    = hdr_hi_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    if (accept && (state_q == StHdrHi)) begin
      hdr_hi_d = in_byte;
    end
    if (accept && (state_q == StHdrLo)) begin
      remaining_d = hdr_cnt;
    end
    if (state_q == StWrite) begin
      remaining_d = remaining_q - HDR_WIDTH'(1);
      addr_d      = addr_q + 32'(WORD_STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi_q    <= '0;
      remaining_q <= '0;
      addr_q      <= BASE_ADDR;
    end else begin
      hdr_hi_q    <= hdr_hi_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        StHdrHi, StHdrLo, StData, StChk: in_ready = 1'b1;
        default:                         in_ready = 1'b0;
      endcase
    end
    mem_we    = (state_q == StWrite);
    done      = (state_q == StDone);
    error     = (state_q == StError);
    cpu_hold  = (state_q != StDone);
    mem_addr  = addr_q;
    mem_wdata = word;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned TbDepth = 256;
  localparam logic [31:0] TbBase  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] img_q[$];
  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];
  logic        we_prev = 1'b0;
  logic [31:0] imem [TbDepth];
  logic [31:0] woff;

  imem_loader #(
    .DEPTH     (TbDepth),
    .BASE_ADDR (TbBase)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor and a simple imem the IFU would fetch from
  always @(negedge clk) begin
    if (mem_we) begin
      chk("we_pulse", 64'(we_prev), 64'd0);
      act_q.push_back({mem_addr, mem_wdata});
    end
    we_prev = mem_we;
  end

  assign woff = (mem_addr - TbBase) >> 2;
  always @(posedge clk) begin
    if (mem_we) imem[woff[7:0]] <= mem_wdata;
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_in_reset", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'(TbBase));
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    act_q.delete();
  endtask

  // gap: 0 = back-to-back, 1 = random idles, 2 = one idle per byte
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n_idle;
    n_idle = (gap == 1) ? int'($urandom_range(0, 2)) : ((gap == 2) ? 1 : 0);
    repeat (n_idle) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 32 && !in_ready; t++) begin
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[31:24], gap);
      t = t << 8;
    end
  endtask

  // Streams img_q (header + words) and checks timing, writes and imem contents
  task automatic run_image(input int gap);
    logic [15:0] hdr;
    logic [7:0]  cks;
    hdr = 16'(img_q.size());
    cks = '0;
    exp_q.delete();
    foreach (img_q[i]) begin
      exp_q.push_back({TbBase + 32'(4 * i), img_q[i]});
      cks = cks ^ img_q[i][31:24] ^ img_q[i][23:16] ^ img_q[i][15:8] ^ img_q[i][7:0];
    end
    send_byte(hdr[15:8], gap);
    send_byte(hdr[7:0], gap);
    foreach (img_q[i]) send_word(img_q[i], gap);
    @(negedge clk);
    chk("last_we", 64'(mem_we), 64'd1);
    chk("done_early", 64'(done), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("chk_ready", 64'(in_ready), 64'd1);
    chk("chk_hold", 64'(cpu_hold), 64'd1);
    send_byte(cks, gap);
`endif
    @(negedge clk);
    chk("done", 64'(done), 64'd1);
    chk("hold_release", 64'(cpu_hold), 64'd0);
    chk("done_we", 64'(mem_we), 64'd0);
    chk("done_ready", 64'(in_ready), 64'd0);
    chk("done_error", 64'(error), 64'd0);
    chk("n_writes", 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk("wr_addr", 64'(act_q[i][63:32]), 64'(exp_q[i][63:32]));
      chk("wr_data", 64'(act_q[i][31:0]), 64'(exp_q[i][31:0]));
    end
    foreach (img_q[i]) chk("ifu_fetch", 64'(imem[i]), 64'(img_q[i]));
  endtask

  initial begin
    do_reset();

    // Directed 3-word image, back-to-back then with in_valid toggling
    img_q = '{32'hCA0F3355, 32'h00330FFF, 32'h20040008};
    run_image(0);
    do_reset();
    run_image(2);

    // Empty image: done straight after the header, nothing else consumed
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_hold", 64'(cpu_hold), 64'd0);
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("empty_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk("empty_writes", 64'(act_q.size()), 64'd0);

    // Oversized header: rejected, no writes, input blocked
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    chk("big_error", 64'(error), 64'd1);
    chk("big_hold", 64'(cpu_hold), 64'd1);
    chk("big_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    repeat (10) begin
      in_byte = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("big_ready", 64'(in_ready), 64'd0);
    chk("big_writes", 64'(act_q.size()), 64'd0);
    chk("big_sticky", 64'(error), 64'd1);

    // Reset in the middle of the first word, then a 1-word reload
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    img_q = '{32'($urandom)};
    run_image(0);

    // Random images with random gaps
    for (int it = 0; it < 8; it++) begin
      int n;
      n = int'($urandom_range(1, 6));
      img_q.delete();
      for (int k = 0; k < n; k++) img_q.push_back(32'($urandom));
      do_reset();
      run_image(int'($urandom_range(0, 2)));
    end

    // Full-capacity image reaches the last address
    img_q.delete();
    for (int k = 0; k < TbDepth; k++) img_q.push_back(32'($urandom));
    do_reset();
    run_image(0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer rejects the image
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h11223344, 0);
    @(negedge clk);
    @(negedge clk);
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h01, 0);
    @(negedge clk);
    chk("cks_error", 64'(error), 64'd1);
    chk("cks_done", 64'(done), 64'd0);
    chk("cks_hold", 64'(cpu_hold), 64'd1);
    chk("cks_writes", 64'(act_q.size()), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
